// File: rtl/window_3x3_line_buffer_if.sv
// Pixel-stream / window bus for the 3x3 line-buffer feeder.
// The master drives the raster pixel stream and observes the window outputs;
// the slave (the line buffer) consumes pixels and produces windows.
interface window_3x3_line_buffer_if #(
    parameter int PIX_W = 8
);
    // Pixel stream side
    logic               sof;
    logic               pix_valid;
    logic [PIX_W-1:0]   pix_in;

    // Window side
    logic [9*PIX_W-1:0] win;
    logic               win_valid;
    logic [9:0]         win_x;
    logic [9:0]         win_y;
    logic               frame_done;

    modport master (
        output sof,
        output pix_valid,
        output pix_in,
        input  win,
        input  win_valid,
        input  win_x,
        input  win_y,
        input  frame_done
    );

    modport slave (
        input  sof,
        input  pix_valid,
        input  pix_in,
        output win,
        output win_valid,
        output win_x,
        output win_y,
        output frame_done
    );
endinterface

// File: rtl/window_3x3_line_buffer.sv
// 3x3 neighbourhood generator for the edge-detection stage.
// Two line buffers hold the previous two rows; a three-column shift window
// combines them with the incoming pixel so that one complete 3x3 window is
// produced per accepted pixel once the window lies fully inside the image.
// Border pixels never produce a window (no edge replication).
module window_3x3_line_buffer #(
    parameter int IMG_W = 222,
    parameter int IMG_H = 138,
    parameter int PIX_W = 8
) (
    input  logic                     PixelClk,
    input  logic                     nRST,
    window_3x3_line_buffer_if.slave  bus
);

    localparam int         AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [9:0] COL_LAST = 10'(IMG_W - 1);
    localparam logic [9:0] ROW_LAST = 10'(IMG_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t               state_r;
    logic [9:0]           col_r;
    logic [9:0]           row_r;
    logic                 frame_done_r;

    // Line buffers: lb0 holds row y-1, lb1 holds row y-2 (never reset)
    logic [PIX_W-1:0]     lb0_r [0:IMG_W-1];
    logic [PIX_W-1:0]     lb1_r [0:IMG_W-1];

    // Shift window columns, packed {top, mid, bottom}; col1 = x-1, col2 = x-2
    logic [3*PIX_W-1:0]   col1_r;
    logic [3*PIX_W-1:0]   col2_r;

    logic [9*PIX_W-1:0]   win_r;
    logic                 win_valid_r;
    logic [9:0]           win_x_r;
    logic [9:0]           win_y_r;

    logic                 restart_s;
    logic                 accept_s;
    logic [9:0]           pos_x_s;
    logic [9:0]           pos_y_s;
    logic [9:0]           next_col_s;
    logic [9:0]           next_row_s;
    logic                 last_pix_s;
    logic                 win_ok_s;
    logic [AW-1:0]        addr_s;
    logic [PIX_W-1:0]     rd0_s;
    logic [PIX_W-1:0]     rd1_s;
    logic [3*PIX_W-1:0]   new_col_s;
    logic [9*PIX_W-1:0]   win_s;

    // Acceptance and effective pixel position (sof forces the pixel to (0,0))
    always_comb begin
        restart_s = bus.sof & bus.pix_valid;
        if (restart_s) begin
            accept_s = 1'b1;
        end else if (bus.pix_valid && (state_r == ST_FILL || state_r == ST_STREAM)) begin
            // A finished frame (DONE) only resumes through a new sof
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end

        if (restart_s) begin
            pos_x_s = 10'd0;
            pos_y_s = 10'd0;
        end else begin
            pos_x_s = col_r;
            pos_y_s = row_r;
        end
    end

    // Raster position bookkeeping for the pixel after the current one
    always_comb begin
        if (pos_x_s == COL_LAST) begin
            next_col_s = 10'd0;
            next_row_s = pos_y_s + 10'd1;
        end else begin
            next_col_s = pos_x_s + 10'd1;
            next_row_s = pos_y_s;
        end
        last_pix_s = (pos_x_s == COL_LAST) && (pos_y_s == ROW_LAST);
        win_ok_s   = (pos_x_s >= 10'd2) && (pos_y_s >= 10'd2);
    end

    // Line-buffer read port and assembly of the candidate 3x3 window
    always_comb begin
        addr_s    = pos_x_s[AW-1:0];
        rd0_s     = lb0_r[addr_s];
        rd1_s     = lb1_r[addr_s];
        new_col_s = {rd1_s, rd0_s, bus.pix_in};
        win_s     = {col2_r[3*PIX_W-1:2*PIX_W], col1_r[3*PIX_W-1:2*PIX_W], rd1_s,
                     col2_r[2*PIX_W-1:PIX_W],   col1_r[2*PIX_W-1:PIX_W],   rd0_s,
                     col2_r[PIX_W-1:0],         col1_r[PIX_W-1:0],         bus.pix_in};
    end

    // Line-buffer write: reads above see the old contents in the same cycle
    always_ff @(posedge PixelClk) begin
        if (accept_s) begin
            lb1_r[addr_s] <= rd0_s;
            lb0_r[addr_s] <= bus.pix_in;
        end
    end

    // Frame FSM with raster counters and the registered frame_done pulse
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            state_r      <= ST_IDLE;
            col_r        <= 10'd0;
            row_r        <= 10'd0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (restart_s) begin
                state_r <= ST_FILL;
                col_r   <= next_col_s;
                row_r   <= next_row_s;
            end else if (accept_s) begin
                col_r <= next_col_s;
                row_r <= next_row_s;
                case (state_r)
                    ST_FILL: begin
                        if (pos_x_s == 10'd0 && pos_y_s == 10'd2) begin
                            state_r <= ST_STREAM;
                        end else begin
                            state_r <= ST_FILL;
                        end
                    end
                    ST_STREAM: begin
                        if (last_pix_s) begin
                            state_r      <= ST_DONE;
                            col_r        <= 10'd0;
                            row_r        <= 10'd0;
                            frame_done_r <= 1'b1;
                        end else begin
                            state_r <= ST_STREAM;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end else if (state_r == ST_DONE) begin
                state_r <= ST_IDLE;
            end else begin
                state_r <= state_r;
            end
        end
    end

    // Column shift registers; history is cleared at the start of every row
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            col1_r <= {(3*PIX_W){1'b0}};
            col2_r <= {(3*PIX_W){1'b0}};
        end else if (accept_s) begin
            if (pos_x_s == 10'd0) begin
                col2_r <= {(3*PIX_W){1'b0}};
            end else begin
                col2_r <= col1_r;
            end
            col1_r <= new_col_s;
        end else begin
            col1_r <= col1_r;
            col2_r <= col2_r;
        end
    end

    // Registered window output; win and position hold when no window is emitted
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            win_r       <= {(9*PIX_W){1'b0}};
            win_valid_r <= 1'b0;
            win_x_r     <= 10'd0;
            win_y_r     <= 10'd0;
        end else if (accept_s && win_ok_s) begin
            win_r       <= win_s;
            win_valid_r <= 1'b1;
            win_x_r     <= pos_x_s - 10'd1;
            win_y_r     <= pos_y_s - 10'd1;
        end else begin
            win_valid_r <= 1'b0;
        end
    end

    assign bus.win        = win_r;
    assign bus.win_valid  = win_valid_r;
    assign bus.win_x      = win_x_r;
    assign bus.win_y      = win_y_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_window_3x3_line_buffer.sv
// Self-checking bench for window_3x3_line_buffer (8x5 image).
// An image-array model predicts each window when the pixel is driven; the
// expectation is queued and compared when the DUT raises win_valid.
module tb_window_3x3_line_buffer;

    localparam int W = 8;
    localparam int H = 5;

    logic PixelClk;
    logic nRST;

    window_3x3_line_buffer_if #(.PIX_W(8)) bus ();

    window_3x3_line_buffer #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .PixelClk (PixelClk),
        .nRST     (nRST),
        .bus      (bus)
    );

    initial PixelClk = 1'b0;
    always #5 PixelClk = ~PixelClk;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [7:0]  img [0:H-1][0:W-1];
    int          mx = 0;
    int          my = 0;
    bit          mdl_active = 1'b0;
    logic        wv_exp = 1'b0;
    logic        fd_exp = 1'b0;
    logic [91:0] exp_q [$];

    // Observation state
    int          pulses = 0;
    int          fd_count = 0;
    int          obs_idx = 0;
    logic [71:0] obs_win [0:31];

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix_of(input int pat, input int x, input int y);
        if (pat == 0) return 8'((y * 8 + x) & 8'hFF);
        else          return 8'(((y * 8 + x) * 7 + 8'h91) & 8'hFF);
    endfunction

    // Drive one cycle of stimulus and predict its outcome
    task automatic drive(input logic s, input logic v, input logic [7:0] p);
        logic        acc;
        logic        wv;
        logic        fd;
        logic [71:0] w;
        bus.sof       = s;
        bus.pix_valid = v;
        bus.pix_in    = p;
        acc = v && (s || mdl_active);
        wv  = 1'b0;
        fd  = 1'b0;
        if (v && s) begin
            mx = 0;
            my = 0;
            mdl_active = 1'b1;
        end
        if (acc) begin
            img[my][mx] = p;
            if (mx >= 2 && my >= 2) begin
                w = {img[my-2][mx-2], img[my-2][mx-1], img[my-2][mx],
                     img[my-1][mx-2], img[my-1][mx-1], img[my-1][mx],
                     img[my][mx-2],   img[my][mx-1],   img[my][mx]};
                exp_q.push_back({w, 10'(mx - 1), 10'(my - 1)});
                wv = 1'b1;
            end
            if (mx == W - 1 && my == H - 1) begin
                fd = 1'b1;
                mdl_active = 1'b0;
                mx = 0;
                my = 0;
            end else if (mx == W - 1) begin
                mx = 0;
                my++;
            end else begin
                mx++;
            end
        end
        @(posedge PixelClk);
        wv_exp = wv;
        fd_exp = fd;
        @(negedge PixelClk);
        #1;
    endtask

    // Send one frame; stop before raster index stop_at (negative = full frame)
    task automatic send_frame(input int pat, input bit toggle, input int stop_at);
        for (int i = 0; i < W * H; i++) begin
            if (i == stop_at) return;
            drive(i == 0, 1'b1, pix_of(pat, i % W, i / W));
            if (toggle) drive(1'b0, 1'b0, 8'hEE);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    // Output monitor, sampled on the falling edge
    always @(negedge PixelClk) begin
        logic [91:0] e;
        if (nRST) begin
            check("win_valid", {71'd0, bus.win_valid}, {71'd0, wv_exp});
            check("frame_done", {71'd0, bus.frame_done}, {71'd0, fd_exp});
            if (bus.frame_done) fd_count++;
            if (bus.win_valid) begin
                pulses++;
                if (obs_idx < 32) obs_win[obs_idx] = bus.win;
                obs_idx++;
                if (exp_q.size() == 0) begin
                    check("win_unexpected", 72'd1, 72'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("win", bus.win, e[91:20]);
                    check("win_x", {62'd0, bus.win_x}, {62'd0, e[19:10]});
                    check("win_y", {62'd0, bus.win_y}, {62'd0, e[9:0]});
                end
            end
        end
    end

    initial begin
        int p0;
        int fd0;
        nRST          = 1'b0;
        bus.sof       = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_in    = 8'h00;
        repeat (3) @(posedge PixelClk);
        @(negedge PixelClk);
        check("rst_win", bus.win, 72'd0);
        check("rst_win_valid", {71'd0, bus.win_valid}, 72'd0);
        check("rst_win_x", {62'd0, bus.win_x}, 72'd0);
        check("rst_win_y", {62'd0, bus.win_y}, 72'd0);
        check("rst_frame_done", {71'd0, bus.frame_done}, 72'd0);
        #1;
        nRST = 1'b1;
        idle(2);

        // Pixels without sof in IDLE are ignored
        drive(1'b0, 1'b1, 8'h55);
        drive(1'b0, 1'b1, 8'h56);
        idle(1);
        check("idle_ignore", 72'(pulses), 72'd0);

        // 1 + 3: full frame, continuous
        p0 = pulses; fd0 = fd_count; obs_idx = 0;
        send_frame(0, 1'b0, -1);
        idle(2);
        check("t1_pulses", 72'(pulses - p0), 72'd18);
        check("t1_frame_done", 72'(fd_count - fd0), 72'd1);
        check("t1_first_win", obs_win[0], 72'h00_01_02_08_09_0A_10_11_12);
        check("t3_row_wrap_win", obs_win[6], 72'h08_09_0A_10_11_12_18_19_1A);

        // 2: same frame with pix_valid toggling
        p0 = pulses; fd0 = fd_count; obs_idx = 0;
        send_frame(0, 1'b1, -1);
        idle(2);
        check("t2_pulses", 72'(pulses - p0), 72'd18);
        check("t2_frame_done", 72'(fd_count - fd0), 72'd1);
        check("t2_first_win", obs_win[0], 72'h00_01_02_08_09_0A_10_11_12);
        check("t2_row_wrap_win", obs_win[6], 72'h08_09_0A_10_11_12_18_19_1A);

        // 4: sof re-asserted at pixel (4,3)
        fd0 = fd_count;
        send_frame(1, 1'b0, 3 * W + 4);
        p0 = pulses; obs_idx = 0;
        send_frame(0, 1'b0, -1);
        idle(2);
        check("t4_pulses", 72'(pulses - p0), 72'd18);
        check("t4_frame_done", 72'(fd_count - fd0), 72'd1);
        check("t4_first_win", obs_win[0], 72'h00_01_02_08_09_0A_10_11_12);

        // 5: reset pulse at pixel (5,3)
        fd0 = fd_count;
        send_frame(1, 1'b0, 3 * W + 5);
        check("t5_q_drain", 72'(exp_q.size()), 72'd0);
        nRST = 1'b0;
        mdl_active = 1'b0;
        wv_exp = 1'b0;
        fd_exp = 1'b0;
        #1;
        check("t5_win_valid", {71'd0, bus.win_valid}, 72'd0);
        check("t5_frame_done", {71'd0, bus.frame_done}, 72'd0);
        check("t5_win", bus.win, 72'd0);
        @(posedge PixelClk);
        @(negedge PixelClk);
        #1;
        nRST = 1'b1;
        p0 = pulses;
        drive(1'b0, 1'b1, 8'h33);
        drive(1'b0, 1'b1, 8'h34);
        drive(1'b0, 1'b1, 8'h35);
        idle(1);
        check("t5_ignored", 72'(pulses - p0), 72'd0);
        check("t5_no_fd", 72'(fd_count - fd0), 72'd0);
        p0 = pulses;
        send_frame(0, 1'b0, -1);
        idle(2);
        check("t5_pulses", 72'(pulses - p0), 72'd18);

        // 6: back-to-back frames with different data
        p0 = pulses; fd0 = fd_count;
        send_frame(0, 1'b0, -1);
        obs_idx = 0;
        send_frame(1, 1'b0, -1);
        idle(2);
        check("t6_pulses", 72'(pulses - p0), 72'd36);
        check("t6_frame_done", 72'(fd_count - fd0), 72'd2);
        check("t6_first_win", obs_win[0],
              {pix_of(1, 0, 0), pix_of(1, 1, 0), pix_of(1, 2, 0),
               pix_of(1, 0, 1), pix_of(1, 1, 1), pix_of(1, 2, 1),
               pix_of(1, 0, 2), pix_of(1, 1, 2), pix_of(1, 2, 2)});

        check("q_left", 72'(exp_q.size()), 72'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
